// File: rtl/cda_pll_pkg.sv
// Shared types for the PLL feedback lock detector.
// Holds the detector state enum and default counter width.
package cda_pll_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        MEASURE,
        LOCKED
    } cda_ld_state_t;

    localparam int CDA_LD_CNT_W = 16;

endpackage

// File: rtl/cda_fb_lock_detect_if.sv
// Bundle between the lock detector and its controller.
// Ports: enable, fb_clk_in, expected_period, tolerance (to detector);
//        period_out, period_valid, locked, loss_of_lock (from detector).
interface cda_fb_lock_detect_if #(
    parameter int CNT_W = 16,
    parameter int TOL_W = 4
);
    logic             enable;
    logic             fb_clk_in;
    logic [CNT_W-1:0] expected_period;
    logic [TOL_W-1:0] tolerance;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             loss_of_lock;

    modport master (
        output enable,
        output fb_clk_in,
        output expected_period,
        output tolerance,
        input  period_out,
        input  period_valid,
        input  locked,
        input  loss_of_lock
    );

    modport slave (
        input  enable,
        input  fb_clk_in,
        input  expected_period,
        input  tolerance,
        output period_out,
        output period_valid,
        output locked,
        output loss_of_lock
    );
endinterface

// File: rtl/cda_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for an async input.
// Ports: clk, reset (sync, active-high), i_d async in, o_rise pulse out.
module cda_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/cda_fb_lock_detect.sv
// Measures the feedback-clock period in clk cycles and declares lock
// after LOCK_COUNT consecutive in-tolerance periods.
// Ports: clk, reset (sync, active-high), bus (slave side of the
//        cda_fb_lock_detect_if bundle: config in, period/lock status out).
module cda_fb_lock_detect
    import cda_pll_pkg::*;
#(
    parameter int CNT_W      = CDA_LD_CNT_W,
    parameter int LOCK_COUNT = 8,
    parameter int TOL_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cda_fb_lock_detect_if.slave  bus
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);

    cda_ld_state_t    r_state;
    cda_ld_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic [MW-1:0]    r_match;
    logic [MW-1:0]    w_match_nxt;
    logic             r_pv;
    logic             w_pv_nxt;
    logic             r_lol;
    logic             w_lol_nxt;
    logic             w_rise;
    logic             w_match;
    logic [CNT_W:0]   w_a;
    logic [CNT_W:0]   w_b;
    logic [CNT_W:0]   w_diff;

    cda_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.fb_clk_in),
        .o_rise (w_rise)
    );

    // One extra bit so the absolute difference never wraps.
    assign w_a     = {1'b0, r_cnt};
    assign w_b     = {1'b0, bus.expected_period};
    assign w_diff  = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_match = (w_diff <= (CNT_W + 1)'(bus.tolerance));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_match_nxt  = r_match;
        w_period_nxt = r_period;
        w_pv_nxt     = 1'b0;
        w_lol_nxt    = 1'b0;
        if (!bus.enable) begin
            // Disable beats a coincident edge and never flags loss.
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_match_nxt = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt   = '0;
                    w_match_nxt = '0;
                    w_state_nxt = ALIGN;
                end
                ALIGN: begin
                    // First edge only starts the count.
                    if (w_rise) begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_pv_nxt     = 1'b1;
                        w_cnt_nxt    = CNT_W'(1);
                        if (w_match) begin
                            if (r_state == MEASURE) begin
                                w_match_nxt = r_match + 1'b1;
                                if (r_match + 1'b1 == LOCK_N)
                                    w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_match_nxt = '0;
                            if (r_state == LOCKED) begin
                                w_state_nxt = MEASURE;
                                w_lol_nxt   = 1'b1;
                            end
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // Feedback clock stopped: realign.
                        w_state_nxt = ALIGN;
                        w_cnt_nxt   = '0;
                        w_match_nxt = '0;
                        w_lol_nxt   = (r_state == LOCKED);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_match  <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_lol    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_match  <= w_match_nxt;
            r_period <= w_period_nxt;
            r_pv     <= w_pv_nxt;
            r_lol    <= w_lol_nxt;
        end
    end

    assign bus.period_out   = r_period;
    assign bus.period_valid = r_pv;
    assign bus.locked       = (r_state == LOCKED);
    assign bus.loss_of_lock = r_lol;
endmodule
